// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: address field widths, FSM state
// encoding and the helper that rebuilds a line-aligned memory address.
package dcache_pkg;

  localparam int unsigned TAG_W      = 23;
  localparam int unsigned INDEX_W    = 4;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WORD_SEL_W = 3;
  localparam int unsigned INDEX_LSB  = OFFSET_W;
  localparam int unsigned TAG_LSB    = OFFSET_W + INDEX_W;
  localparam int unsigned WORD_LSB   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StMiss,
    StWriteback,
    StAllocate,
    StRefillDone
  } state_e;

  // Line-aligned byte address: offset bits are always zero.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the direct-mapped data cache: valid/dirty bits, tags and line data.
// Ports:
//   clk_i, rst_i     clock; synchronous active-high reset (clears valid and dirty only)
//   index_i          line selected for both the read and the write port
//   valid_o .. line_o combinational read of the selected line
//   fill_*           full-line write: loads tag and data, valid=1, dirty=0
//   word_*           single-word write into the selected line, sets dirty
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned LINE_W    = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    index_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [LINE_W-1:0]     line_o,
  input  logic                  fill_en_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [LINE_W-1:0]     fill_line_i,
  input  logic                  word_en_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [31:0]           word_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (word_en_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_line_i;
    end else if (word_en_i) begin
      data_q[index_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Misses stall the pipeline while a dirty victim is written back and the line
// is refilled from the 256-bit memory.
// Ports:
//   clk_i, rst_i                  clock; synchronous active-high reset
//   cpu_addr_i, cpu_data_i        MEM-stage byte address and store data
//   cpu_MemRead_i/cpu_MemWrite_i  load / store request (store wins if both)
//   cpu_data_o, cpu_stall_o       load data (hit cycle only), pipeline freeze
//   mem_addr_o, mem_data_o        line-aligned address, write-back line
//   mem_enable_o, mem_write_o     memory request, 1 = write
//   mem_data_i, mem_ack_i         refill line, single-cycle completion pulse
// Build option: define DCACHE_PERF_CNT_EN to add saturating hit_cnt_o/miss_cnt_o.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_W    = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  state_e state_q, state_d;
  logic   mem_enable_q, mem_write_q;

  logic                  req, hit, idle_hit;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    index;
  logic [WORD_SEL_W-1:0] word_sel;

  logic               line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [LINE_W-1:0]  line_data;
  logic               fill_en, word_en;

  logic unused_addr;
  assign unused_addr = ^cpu_addr_i[WORD_LSB-1:0];

  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign req_tag  = cpu_addr_i[TAG_LSB +: TAG_W];
  assign index    = cpu_addr_i[INDEX_LSB +: INDEX_W];
  assign word_sel = cpu_addr_i[WORD_LSB +: WORD_SEL_W];

  assign hit      = line_valid && (line_tag == req_tag);
  // Requests are only serviced from IDLE; the post-refill bubble still stalls.
  assign idle_hit = (state_q == StIdle) && hit;

  assign cpu_stall_o = req && !idle_hit;
  assign cpu_data_o  = (idle_hit && cpu_MemRead_i && !cpu_MemWrite_i) ?
                       line_data[{word_sel, 5'b0} +: 32] : 32'h0;

  assign fill_en = (state_q == StAllocate) && mem_ack_i && !rst_i;
  assign word_en = idle_hit && cpu_MemWrite_i && !rst_i;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .index_i     (index),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data),
    .fill_en_i   (fill_en),
    .fill_tag_i  (req_tag),
    .fill_line_i (mem_data_i),
    .word_en_i   (word_en),
    .word_sel_i  (word_sel),
    .word_data_i (cpu_data_i)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (req && !hit) state_d = StMiss;
      StMiss:       state_d = (line_valid && line_dirty) ? StWriteback : StAllocate;
      StWriteback:  if (mem_ack_i) state_d = StAllocate;
      StAllocate:   if (mem_ack_i) state_d = StRefillDone;
      StRefillDone: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= (state_d == StWriteback) || (state_d == StAllocate);
      mem_write_q  <= (state_d == StWriteback);
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;

  // Address and write-back data are stable through a transaction: the CPU holds
  // its request and the victim line is untouched until the refill lands.
  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    if (state_q == StWriteback) begin
      mem_addr_o = ADDR_W'(line_addr(line_tag, index));
      mem_data_o = line_data;
    end else if (state_q == StAllocate) begin
      mem_addr_o = ADDR_W'(line_addr(req_tag, index));
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // The cycle after REFILL_DONE re-evaluates an already-counted request.
  logic        reeval_q, count_en;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign count_en = (state_q == StIdle) && req && !reeval_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reeval_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      reeval_q <= (state_q == StRefillDone);
      if (count_en && hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (count_en && !hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: stimulus pushes expected load data and
// expected memory transactions; monitors pop and compare when the DUT presents them.
module tb_dcache_controller;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_rd, cpu_wr;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int en_cycles = 0;

  logic [31:0]  rd_exp_q [$];
  mem_txn_t     mem_exp_q [$];
  logic [255:0] mem [logic [26:0]];

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [255:0] data);
    mem_txn_t t;
    t.wr = wr;
    t.addr = addr;
    t.data = data;
    mem_exp_q.push_back(t);
  endtask

  // Issue one request, hold it while stalled, release after the serviced cycle.
  task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls);
    @(posedge clk); #1;
    cpu_addr = addr;
    cpu_wdata = wdata;
    cpu_rd = !wr;
    cpu_wr = wr;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: addr %0h still stalled after %0d cycles", addr, stalls);
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // Load-data monitor: one completion per non-stalled read cycle.
  always @(negedge clk) begin
    if (!rst && cpu_rd && !cpu_wr && !cpu_stall_o) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_unexpected_read: got %0h expected no read", cpu_data_o);
      end else begin
        check("cpu_rdata", {224'h0, cpu_data_o}, {224'h0, rd_exp_q.pop_front()});
      end
    end
  end

  // Memory model + transaction monitor; acks after mem_lat enabled cycles.
  initial begin
    mem_txn_t     t;
    bit           busy;
    int           wait_cnt;
    logic         cur_wr;
    logic [31:0]  cur_addr;
    busy = 1'b0;
    wait_cnt = 0;
    cur_wr = 1'b0;
    cur_addr = '0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (rst || !mem_enable_o) begin
        busy = 1'b0;
      end else begin
        en_cycles++;
        if (!busy) begin
          busy = 1'b1;
          wait_cnt = 0;
          cur_wr = mem_write_o;
          cur_addr = mem_addr_o;
        end else begin
          check("mem_req_stable", {223'h0, mem_write_o, mem_addr_o}, {223'h0, cur_wr, cur_addr});
        end
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          busy = 1'b0;
          mem_ack_i = 1'b1;
          if (mem_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected_req: got wr=%0b addr=%0h expected none",
                     mem_write_o, mem_addr_o);
          end else begin
            t = mem_exp_q.pop_front();
            check("mem_write", {255'h0, mem_write_o}, {255'h0, t.wr});
            check("mem_addr", {224'h0, mem_addr_o}, {224'h0, t.addr});
            if (t.wr) check("mem_wb_data", mem_data_o, t.data);
          end
          if (mem_write_o) mem[mem_addr_o[31:5]] = mem_data_o;
          else mem_data_i = mem.exists(mem_addr_o[31:5]) ? mem[mem_addr_o[31:5]] : '0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st, n;
    logic [255:0] line40, wb40, wb1000;
    line40 = mk_line(32'hA000_0000);
    line40[95:64] = 32'h1234_5678;
    mem[27'h2]   = line40;                      // 0x0000_0040
    mem[27'h12]  = mk_line(32'hB000_0000);      // 0x0000_0240
    mem[27'h80]  = mk_line(32'hC000_0000);      // 0x0000_1000
    mem[27'h180] = mk_line(32'hD000_0000);      // 0x0000_3000
    mem[27'h4]   = mk_line(32'hE000_0000);      // 0x0000_0080

    rst = 1'b1;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {255'h0, cpu_stall_o}, 256'h0);
    check("rst_mem_enable", {255'h0, mem_enable_o}, 256'h0);
    check("rst_mem_write", {255'h0, mem_write_o}, 256'h0);
    check("rst_mem_addr", {224'h0, mem_addr_o}, 256'h0);
    check("rst_mem_data", mem_data_o, 256'h0);
    check("rst_cpu_data", {224'h0, cpu_data_o}, 256'h0);

    // Cold read miss, clean victim.
    push_mem(1'b0, 32'h40, '0);
    rd_exp_q.push_back(32'h1234_5678);
    cpu_op(1'b0, 32'h48, 32'h0, st);
    check("cold_read_stalls", 256'(st), 256'd4);
`ifdef DCACHE_PERF_CNT_EN
    check("cold_hit_cnt", {224'h0, hit_cnt}, 256'd0);
    check("cold_miss_cnt", {224'h0, miss_cnt}, 256'd1);
`endif

    rd_exp_q.push_back(32'hA000_0001);
    cpu_op(1'b0, 32'h44, 32'h0, st);
    check("read_hit_stalls", 256'(st), 256'd0);

    cpu_op(1'b1, 32'h40, 32'hDEAD_BEEF, st);
    check("write_hit_stalls", 256'(st), 256'd0);
    rd_exp_q.push_back(32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h40, 32'h0, st);

    // Dirty victim: write-back then allocate.
    wb40 = line40;
    wb40[31:0] = 32'hDEAD_BEEF;
    push_mem(1'b1, 32'h40, wb40);
    push_mem(1'b0, 32'h240, '0);
    rd_exp_q.push_back(32'hB000_0000);
    cpu_op(1'b0, 32'h240, 32'h0, st);
    check("dirty_miss_stalls", 256'(st), 256'd5);

    // Refetch proves the written-back line reached memory.
    push_mem(1'b0, 32'h40, '0);
    rd_exp_q.push_back(32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h40, 32'h0, st);
    check("clean_refetch_stalls", 256'(st), 256'd4);

    // Write miss on an invalid line: allocate only, store merged after refill.
    push_mem(1'b0, 32'h1000, '0);
    cpu_op(1'b1, 32'h1000, 32'h0BAD_F00D, st);
    check("write_miss_stalls", 256'(st), 256'd4);
    rd_exp_q.push_back(32'h0BAD_F00D);
    cpu_op(1'b0, 32'h1000, 32'h0, st);
    rd_exp_q.push_back(32'hC000_0001);
    cpu_op(1'b0, 32'h1004, 32'h0, st);

    wb1000 = mk_line(32'hC000_0000);
    wb1000[31:0] = 32'h0BAD_F00D;
    push_mem(1'b1, 32'h1000, wb1000);
    push_mem(1'b0, 32'h3000, '0);
    rd_exp_q.push_back(32'hD000_0001);
    cpu_op(1'b0, 32'h3004, 32'h0, st);
    check("write_miss_dirty_evict_stalls", 256'(st), 256'd5);

    // Slow memory: request held for the whole latency, issued once.
    mem_lat = 10;
    en_cycles = 0;
    push_mem(1'b0, 32'h80, '0);
    rd_exp_q.push_back(32'hE000_0002);
    cpu_op(1'b0, 32'h88, 32'h0, st);
    check("slow_mem_stalls", 256'(st), 256'd13);
    check("slow_mem_enable_cycles", 256'(en_cycles), 256'd10);
    mem_lat = 1;

    // Reset during write-back abandons the transaction and invalidates lines.
    cpu_op(1'b1, 32'h40, 32'h1111_2222, st);
    mem_lat = 20;
    @(posedge clk); #1;
    cpu_addr = 32'h440;
    cpu_rd = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_enable_o && n < 20);
    check("wb_started", {254'h0, mem_enable_o, mem_write_o}, 256'h3);
    repeat (3) @(negedge clk);
    check("wb_stall_held", {255'h0, cpu_stall_o}, 256'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_mem_enable", {255'h0, mem_enable_o}, 256'h0);
    check("midrst_mem_write", {255'h0, mem_write_o}, 256'h0);
    check("midrst_mem_addr", {224'h0, mem_addr_o}, 256'h0);
    check("midrst_stall", {255'h0, cpu_stall_o}, 256'h0);
    mem_lat = 1;
    push_mem(1'b0, 32'h40, '0);
    rd_exp_q.push_back(32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h40, 32'h0, st);
    check("post_rst_miss_stalls", 256'(st), 256'd4);
`ifdef DCACHE_PERF_CNT_EN
    check("post_rst_hit_cnt", {224'h0, hit_cnt}, 256'd0);
    check("post_rst_miss_cnt", {224'h0, miss_cnt}, 256'd1);
`endif

    repeat (3) @(posedge clk);
    check("rd_queue_drained", 256'(rd_exp_q.size()), 256'd0);
    check("mem_queue_drained", 256'(mem_exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
